// File: rtl/dram_resp.sv
// dram_resp: on-chip DRAM responder for the conv/pool engines.
//   Holds MEM_DEPTH words. Writes land on the sampling edge. Reads return
//   after RD_LAT cycles, in request order, qualified by dram_valid.
//   After srst the array can be zeroed one word per cycle (busy=1) before
//   any request is served.
// Ports:
//   clk, srst                 clock, synchronous active-high reset
//   dram_en_rd, addr_in       read strobe and read address
//   dram_en_wr, addr_out,     write strobe, write address and write data
//   wr_data
//   rd_data, dram_valid       read return data and its qualifier
//   busy                      clear sequence running; requests are ignored
//   err                       sticky: out-of-range request or request while busy
//   rd_cnt, wr_cnt            serviced in-range reads/writes, saturating
module dram_resp #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 18,
  parameter int MEM_DEPTH      = 4096,
  parameter int RD_LAT         = 2,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  dram_en_rd,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic                  dram_en_wr,
  input  logic [ADDR_WIDTH-1:0] addr_out,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  dram_valid,
  output logic                  busy,
  output logic                  err,
  output logic [15:0]           rd_cnt,
  output logic [15:0]           wr_cnt
);

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] SERVE = 1'b1;

  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [IW-1:0]       LAST    = IW'(MEM_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] clr_ptr_q, clr_ptr_d;

  logic serve, clearing;
  logic rd_in, wr_in, rd_acc, rd_ok, wr_ok, err_ev;

  // Range check by full compare so out-of-range addresses never alias.
  assign rd_in    = {1'b0, addr_in}  < DEPTH_A;
  assign wr_in    = {1'b0, addr_out} < DEPTH_A;
  assign serve    = (state_q == SERVE);
  assign clearing = !serve && !srst;
  assign rd_acc   = serve && !srst && dram_en_rd;   // produces a valid pulse
  assign rd_ok    = rd_acc && rd_in;                // real RAM read
  assign wr_ok    = serve && !srst && dram_en_wr && wr_in;
  assign err_ev   = (!serve && (dram_en_rd || dram_en_wr)) ||
                    (serve && ((dram_en_rd && !rd_in) || (dram_en_wr && !wr_in)));

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (clearing) begin
      clr_ptr_d = clr_ptr_q + 1'b1;
      if (clr_ptr_q == LAST) begin
        state_d   = SERVE;
        clr_ptr_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? CLEAR : SERVE;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Single write port shared by the clear sequence and requesters.
  always_ff @(posedge clk) begin
    if (clearing)   mem[clr_ptr_q]      <= '0;
    else if (wr_ok) mem[addr_out[IW-1:0]] <= wr_data;
  end

  // Registered read: samples the word before a same-edge write lands.
  logic [DATA_WIDTH-1:0] ram_q;
  always_ff @(posedge clk) begin
    if (rd_ok) ram_q <= mem[addr_in[IW-1:0]];
  end

  // oor_q masks ram_q for out-of-range reads; reset to 1 so the first
  // stage reads as zero before any read has been accepted.
  logic oor_q;
  always_ff @(posedge clk) begin
    if (srst)        oor_q <= 1'b1;
    else if (rd_acc) oor_q <= !rd_in;
  end

  logic [DATA_WIDTH-1:0] stg0;
  assign stg0 = oor_q ? '0 : ram_q;

  // vld_q[0] marks the RAM-read stage; vld_q[RD_LAT] is the output.
  logic [RD_LAT:0]                  vld_q;
  logic [RD_LAT:1][DATA_WIDTH-1:0]  stg_q;

  always_ff @(posedge clk) begin
    if (srst) vld_q <= '0;
    else      vld_q <= {vld_q[RD_LAT-1:0], rd_acc};
  end

  // Data stages advance only behind a valid, so the output holds its
  // last returned word while dram_valid is low.
  always_ff @(posedge clk) begin
    if (srst) begin
      stg_q <= '0;
    end else begin
      if (vld_q[0]) stg_q[1] <= stg0;
      for (int k = 2; k <= RD_LAT; k++)
        if (vld_q[k-1]) stg_q[k] <= stg_q[k-1];
    end
  end

  logic [15:0] rd_cnt_q, wr_cnt_q;
  logic        err_q;

  always_ff @(posedge clk) begin
    if (srst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (rd_ok && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      if (wr_ok && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
      if (err_ev)                        err_q    <= 1'b1;
    end
  end

  assign rd_data    = stg_q[RD_LAT];
  assign dram_valid = vld_q[RD_LAT];
  assign busy       = !serve;
  assign err        = err_q;
  assign rd_cnt     = rd_cnt_q;
  assign wr_cnt     = wr_cnt_q;

endmodule

// File: tb/tb_dram_resp.sv
// Randomized and directed bench for dram_resp (MEM_DEPTH=16, RD_LAT=2).
// A behavioural model (array + counters) updates on every sampling edge and
// pushes expected read returns into a queue; a negedge monitor pops them.
module tb_dram_resp;
  localparam int DW = 32;
  localparam int AW = 18;
  localparam int DEPTH = 16;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          srst;
  logic          dram_en_rd, dram_en_wr;
  logic [AW-1:0] addr_in, addr_out;
  logic [DW-1:0] wr_data, rd_data;
  logic          dram_valid, busy, err;
  logic [15:0]   rd_cnt, wr_cnt;

  dram_resp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH),
              .RD_LAT(LAT), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .srst(srst),
    .dram_en_rd(dram_en_rd), .addr_in(addr_in),
    .dram_en_wr(dram_en_wr), .addr_out(addr_out), .wr_data(wr_data),
    .rd_data(rd_data), .dram_valid(dram_valid), .busy(busy), .err(err),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [DW-1:0] d; int due; } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [DW-1:0] m_mem [DEPTH];
  int            m_busy_left = 0;
  logic          m_err = 1'b0;
  int            m_rd = 0, m_wr = 0;
  logic [DW-1:0] m_last = '0;
  bit            mon_en = 1'b0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // One request cycle: check status at negedge, drive, then model the edge.
  task automatic drive(input bit rst, input bit rd, input int ra,
                       input bit wr, input int wa, input logic [DW-1:0] wd);
    int t;
    @(negedge clk);
    if (mon_en) begin
      chk("busy",   DW'(busy),   DW'(m_busy_left > 0));
      chk("err",    DW'(err),    DW'(m_err));
      chk("rd_cnt", DW'(rd_cnt), DW'(m_rd));
      chk("wr_cnt", DW'(wr_cnt), DW'(m_wr));
    end
    srst = rst; dram_en_rd = rd; addr_in = AW'(ra);
    dram_en_wr = wr; addr_out = AW'(wa); wr_data = wd;
    @(posedge clk);
    t = cyc;
    if (rst) begin
      sbq.delete();
      m_err = 1'b0; m_rd = 0; m_wr = 0; m_last = '0;
      m_busy_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      mon_en = 1'b1;
    end else if (m_busy_left > 0) begin
      if (rd || wr) m_err = 1'b1;
      m_busy_left--;
    end else begin
      if (rd) begin
        if (ra < DEPTH) begin
          sbq.push_back('{d: m_mem[ra], due: t + LAT});
          if (m_rd < 65535) m_rd++;
        end else begin
          sbq.push_back('{d: '0, due: t + LAT});
          m_err = 1'b1;
        end
      end
      if (wr) begin
        if (wa < DEPTH) begin
          m_mem[wa] = wd;
          if (m_wr < 65535) m_wr++;
        end else m_err = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, '0);
  endtask

  // Monitor: edge index of the most recent posedge is cyc-1.
  always @(negedge clk) begin
    int e;
    if (mon_en) begin
      e = cyc - 1;
      if (sbq.size() > 0 && sbq[0].due == e) begin
        chk("dram_valid", DW'(dram_valid), DW'(1));
        chk("rd_data", rd_data, sbq[0].d);
        m_last = sbq[0].d;
        void'(sbq.pop_front());
      end else begin
        chk("valid_idle", DW'(dram_valid), DW'(0));
        chk("rd_hold", rd_data, m_last);
      end
      if (sbq.size() > 0 && sbq[0].due < e) begin
        chk("late_return", DW'(sbq[0].due), DW'(e));
        void'(sbq.pop_front());
      end
    end
  end

  initial begin
    srst = 1'b1; dram_en_rd = 0; dram_en_wr = 0;
    addr_in = '0; addr_out = '0; wr_data = '0;
    // 1: reset, clear period, reads of every word return zero
    drive(1, 0, 0, 0, 0, '0);
    drive(1, 0, 0, 0, 0, '0);
    idle(DEPTH);
    for (int a = 0; a < DEPTH; a++) drive(0, 1, a, 0, 0, '0);
    idle(LAT + 1);
    // 2: write then read back
    drive(0, 0, 0, 1, 5, 32'h0000_1234);
    drive(0, 1, 5, 0, 0, '0);
    idle(LAT + 1);
    // 3: streaming writes and back-to-back reads
    for (int a = 0; a < 10; a++) drive(0, 0, 0, 1, a, DW'(a * 3));
    for (int a = 0; a < 10; a++) drive(0, 1, a, 0, 0, '0);
    idle(LAT + 1);
    // 4: same-address read/write returns the old word
    drive(0, 0, 0, 1, 7, 32'h0000_AAAA);
    drive(0, 1, 7, 1, 7, 32'h0000_BBBB);
    drive(0, 1, 7, 0, 0, '0);
    idle(LAT + 1);
    // 5: out-of-range read/write, then no aliasing onto 14
    drive(0, 1, 20, 1, 30, 32'hDEAD_BEEF);
    drive(0, 0, 0, 1, 4, 32'h0000_0044);
    drive(0, 1, 14, 0, 0, '0);
    idle(LAT + 1);
    // 6: reads killed by reset, request during clear sets err
    drive(0, 1, 3, 0, 0, '0);
    drive(0, 1, 4, 0, 0, '0);
    drive(1, 0, 0, 0, 0, '0);
    drive(0, 1, 2, 1, 2, 32'h1111_2222);
    idle(DEPTH + 2);
    // random traffic with occasional resets
    for (int i = 0; i < 600; i++)
      drive(($urandom_range(0, 149) == 0), $urandom_range(0, 1), $urandom_range(0, 19),
            $urandom_range(0, 1), $urandom_range(0, 19), $urandom());
    idle(DEPTH + LAT + 3);
    chk("sb_drained", DW'(sbq.size()), DW'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
